pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. Takes hazard, branch and memory-wait information from the ID, EXE and MEM stages. Drives the `freeze` and `flush` inputs of the PC, IF/ID and ID/EXE stage registers. Replaces the ad-hoc freeze/flush wiring in the top level, adds deferred-branch handling during multi-cycle SRAM waits, and adds a stall performance counter.

## Interface
Parameters:
- `FORWARD_EN`, default 1. 1 means only load-use hazards stall. 0 means any RAW hazard against EXE or MEM stalls.
- `TIMEOUT`, default 255. Maximum number of cycles in a memory wait before `mem_timeout` is set.
- `CNT_W`, default 16. Width of the stall counter.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `id_src1`, in, 4: ID-stage source register 1.
- `id_src2`, in, 4: ID-stage source register 2.
- `id_two_src`, in, 1: ID instruction reads `id_src2`.
- `id_valid`, in, 1: ID holds a real (non-bubble) instruction.
- `exe_dest`, in, 4: EXE-stage destination register.
- `exe_wb_en`, in, 1: EXE instruction writes back.
- `exe_mem_r_en`, in, 1: EXE instruction is a load.
- `mem_dest`, in, 4: MEM-stage destination register.
- `mem_wb_en`, in, 1: MEM instruction writes back.
- `branch_taken`, in, 1: EXE resolved a taken branch (one-cycle pulse).
- `mem_req`, in, 1: MEM stage starts an SRAM access this cycle.
- `mem_ready`, in, 1: SRAM access completes this cycle.
- `pc_freeze`, out, 1: hold the PC register.
- `if_id_freeze`, out, 1: hold the IF/ID register.
- `if_id_flush`, out, 1: clear IF/ID to a NOP.
- `id_exe_flush`, out, 1: insert a bubble into ID/EXE.
- `pipe_freeze`, out, 1: hold ID/EXE, EXE/MEM and MEM/WB.
- `mem_timeout`, out, 1: sticky error flag.
- `stall_count`, out, CNT_W: saturating count of stall cycles.

## Operation
- **Hazard (combinational).** `hz` is true when `id_valid` is set and either of these holds:
  - `id_src1` matches a hazard destination;
  - `id_two_src` is set and `id_src2` matches a hazard destination.
- **Hazard destinations.**
  - FORWARD_EN=1: `exe_dest` when `exe_wb_en && exe_mem_r_en`.
  - FORWARD_EN=0: `exe_dest` when `exe_wb_en`, or `mem_dest` when `mem_wb_en`.
- **FSM states:** RUN, MEM_WAIT, BR_PEND.
- **RUN:**
  - `mem_req && !mem_ready` → MEM_WAIT.
  - `mem_req && branch_taken && !mem_ready` → BR_PEND.
  - Otherwise stay in RUN.
- **MEM_WAIT:**
  - `mem_ready` → RUN.
  - `branch_taken` (without `mem_ready`) → BR_PEND.
- **BR_PEND:** `mem_ready` → RUN, and the pending flush is applied in that same cycle.
- **Outputs, highest priority first:**
  1. **Memory wait** (state MEM_WAIT or BR_PEND without `mem_ready`, or RUN with `mem_req && !mem_ready`): `pc_freeze`=`if_id_freeze`=`pipe_freeze`=1; both flushes 0.
  2. **Branch** (`branch_taken` in RUN, or `mem_ready` in BR_PEND): `if_id_flush`=`id_exe_flush`=1; freezes 0.
  3. **Hazard** (`hz`): `pc_freeze`=`if_id_freeze`=`id_exe_flush`=1; `pipe_freeze`=0.
  4. **Otherwise:** all outputs 0.
- **Same-cycle events:** a branch beats a hazard, because the hazard instruction is flushed anyway.
- **Wait counter:** `wait_cnt` clears on entry to MEM_WAIT or BR_PEND and increments each wait cycle.
- **Timeout:** when `wait_cnt` = TIMEOUT, `mem_timeout` is set and stays 1 until reset. The FSM keeps waiting; there is no forced exit.
- **Stall counter:** `stall_count` increments every cycle in which `pc_freeze` is 1. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- **Reset:** `rst`=0 at a rising edge puts the state in RUN and clears `wait_cnt`, `stall_count` and `mem_timeout`. This applies mid-operation too, and discards any pending branch.
- **During reset:** the combinational outputs still follow the inputs, with the FSM seen as RUN.
- **Latency:**
  - Hazard and branch responses take zero cycles (combinational from the inputs).
  - The FSM changes state one edge after the triggering input.
  - A load-use hazard stalls exactly 1 cycle, because the load then moves to MEM and `hz` drops.
- **Single-cycle SRAM access:** `mem_req && mem_ready` in the same cycle causes no freeze and no state change.
- **Branch pulse:** `branch_taken` is sampled only in RUN and MEM_WAIT. A second pulse in BR_PEND is ignored, since EXE is frozen and cannot produce one legally.
- **Saturation:** `stall_count` stays at its maximum value once reached.

## Test plan
- **Load-use, FORWARD_EN=1:** `exe_mem_r_en`=1, `exe_wb_en`=1, `exe_dest`=3, `id_src1`=3 → `pc_freeze`, `if_id_freeze` and `id_exe_flush` are 1 for one cycle; `stall_count` reads 1.
- **Non-load RAW:** same as above but `exe_mem_r_en`=0 → no stall with FORWARD_EN=1; 1 cycle of stall with FORWARD_EN=0.
- **Memory wait:** `mem_req` pulse, `mem_ready` asserted 4 cycles later → `pipe_freeze`=1 for 4 cycles; state returns to RUN; `stall_count`=4.
- **Deferred branch:** `branch_taken` on the 2nd wait cycle, `mem_ready` on the 5th → no flush until the 5th cycle; then `if_id_flush`=`id_exe_flush`=1 for exactly that cycle.
- **Timeout and reset:** TIMEOUT=8, `mem_ready` held low 10 cycles → `mem_timeout` rises on wait cycle 8 and stays set. Driving `rst`=0 for one edge → `mem_timeout`=0, `stall_count`=0, state RUN.
- **Simultaneous events:** `branch_taken` together with `hz` → flushes only, no freezes. `mem_req` together with `branch_taken` and `mem_ready`=0 → freeze now, flush on the later `mem_ready`.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use / RAW hazard stalls,
// SRAM wait freezes with deferred branch flush, wait timeout flag and a stall counter.
module pipeline_hazard_ctrl #(
   parameter int FORWARD_EN = 1,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_two_src,
   input  logic             id_valid,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             if_id_freeze,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      BR_PEND  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_eff;
   state_t          state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic [WC_W-1:0] wait_cnt_nxt;

   logic exe_hz_en;
   logic mem_hz_en;
   logic src1_hit;
   logic src2_hit;
   logic hz;
   logic mem_wait;
   logic branch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [WC_W-1:0] wc_inc(input logic [WC_W-1:0] v);
      return (v == WC_MAX) ? v : v + WC_W'(1);
   endfunction

   // With forwarding only a load in EXE cannot be bypassed; without it every pending write blocks.
   always_comb begin
      exe_hz_en = (FORWARD_EN != 0) ? (exe_wb_en && exe_mem_r_en) : exe_wb_en;
      mem_hz_en = (FORWARD_EN != 0) ? 1'b0 : mem_wb_en;
      src1_hit  = (exe_hz_en && (id_src1 == exe_dest)) || (mem_hz_en && (id_src1 == mem_dest));
      src2_hit  = (exe_hz_en && (id_src2 == exe_dest)) || (mem_hz_en && (id_src2 == mem_dest));
      hz        = id_valid && (src1_hit || (id_two_src && src2_hit));
   end

   // While reset is asserted the outputs still track the inputs as if idle in RUN.
   assign state_eff = rst ? state : RUN;

   always_comb begin
      mem_wait = 1'b0;
      branch   = 1'b0;
      case (state_eff)
         RUN: begin
            mem_wait = mem_req && !mem_ready;
            branch   = branch_taken;
         end
         MEM_WAIT: mem_wait = !mem_ready;
         BR_PEND: begin
            mem_wait = !mem_ready;
            branch   = mem_ready;
         end
         default: mem_wait = 1'b0;
      endcase
   end

   always_comb begin
      pc_freeze    = 1'b0;
      if_id_freeze = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      pipe_freeze  = 1'b0;
      if (mem_wait) begin
         pc_freeze    = 1'b1;
         if_id_freeze = 1'b1;
         pipe_freeze  = 1'b1;
      end else if (branch) begin
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
      end else if (hz) begin
         pc_freeze    = 1'b1;
         if_id_freeze = 1'b1;
         id_exe_flush = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state_eff;
      case (state_eff)
         RUN: begin
            if (mem_req && !mem_ready)
               state_nxt = branch_taken ? BR_PEND : MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_ready)
               state_nxt = RUN;
            else if (branch_taken)
               state_nxt = BR_PEND;
         end
         BR_PEND: begin
            if (mem_ready)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // The entry cycle (the RUN cycle that raised the wait) counts as wait cycle 1.
   assign wait_cnt_nxt = (state_eff == RUN) ? WC_W'(1) : wc_inc(wait_cnt);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         state <= state_nxt;
         if (pc_freeze)
            stall_count <= sat_inc(stall_count);
         if (mem_wait) begin
            wait_cnt <= wait_cnt_nxt;
            if (wait_cnt_nxt == WC_MAX)
               mem_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// two instances (forwarding on / off) compared against a set-based reference model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       branch_taken, mem_req, mem_ready;

   logic        a_pcf, a_iff, a_ifl, a_iel, a_pf, a_to;
   logic        b_pcf, b_iff, b_ifl, b_iel, b_pf, b_to;
   logic [3:0]  a_sc;
   logic [15:0] b_sc;
   logic [5:0]  a_o, b_o;

   assign a_o = {a_pcf, a_iff, a_ifl, a_iel, a_pf, a_to};
   assign b_o = {b_pcf, b_iff, b_ifl, b_iel, b_pf, b_to};

   int vec  = 0;
   int miss = 0;

   // Model state: waiting on SRAM, branch deferred, wait cycles seen, timeout, stall total.
   bit m_wait [2];
   bit m_pend [2];
   int m_wc   [2];
   bit m_to   [2];
   int m_stall[2];
   int m_max  [2] = '{15, 65535};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FORWARD_EN(1), .TIMEOUT(8), .CNT_W(4)) dut_fwd (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_valid(id_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_freeze(a_pcf), .if_id_freeze(a_iff), .if_id_flush(a_ifl),
      .id_exe_flush(a_iel), .pipe_freeze(a_pf), .mem_timeout(a_to), .stall_count(a_sc));

   pipeline_hazard_ctrl #(.FORWARD_EN(0), .TIMEOUT(8), .CNT_W(16)) dut_nofwd (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .id_valid(id_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_freeze(b_pcf), .if_id_freeze(b_iff), .if_id_flush(b_ifl),
      .id_exe_flush(b_iel), .pipe_freeze(b_pf), .mem_timeout(b_to), .stall_count(b_sc));

   // k=0: forwarding instance, k=1: no-forwarding instance.
   function automatic bit hz_of(int k);
      bit [15:0] busy = '0;
      if (k == 0) begin
         if (exe_wb_en && exe_mem_r_en) busy[exe_dest] = 1'b1;
      end else begin
         if (exe_wb_en) busy[exe_dest] = 1'b1;
         if (mem_wb_en) busy[mem_dest] = 1'b1;
      end
      return id_valid && (busy[id_src1] || (id_two_src && busy[id_src2]));
   endfunction

   // Returns {pc_freeze, if_id_freeze, if_id_flush, id_exe_flush, pipe_freeze}.
   function automatic logic [4:0] exp_comb(int k);
      bit w, p, mw, br, h;
      w  = rst && m_wait[k];
      p  = rst && m_pend[k];
      mw = w ? !mem_ready : (mem_req && !mem_ready);
      br = !mw && ((!w && branch_taken) || (p && mem_ready));
      h  = !mw && !br && hz_of(k);
      return {mw || h, mw || h, br, br || h, mw};
   endfunction

   task automatic model_edge();
      logic [4:0] e;
      for (int k = 0; k < 2; k++) begin
         e = exp_comb(k);
         if (!rst) begin
            m_wait[k] = 0; m_pend[k] = 0; m_wc[k] = 0; m_to[k] = 0; m_stall[k] = 0;
         end else begin
            if (e[4] && m_stall[k] < m_max[k]) m_stall[k]++;
            if (e[0]) begin
               if (!m_wait[k]) begin
                  m_wc[k]   = 1;
                  m_pend[k] = branch_taken;
               end else begin
                  m_wc[k]++;
                  m_pend[k] = m_pend[k] | branch_taken;
               end
               m_wait[k] = 1;
               if (m_wc[k] >= 8) m_to[k] = 1;
            end else begin
               m_wait[k] = 0;
               m_pend[k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 0; id_valid = 0;
      exe_dest = 4'd0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4'd0; mem_wb_en = 0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic load_use_inputs();
      id_valid = 1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      load_use_inputs();
      rst = 0;
      @(negedge clk);
      vec++;
      if (a_pcf !== 1'b1 || a_iel !== 1'b1) begin
         miss++; $display("FAIL reset_comb: pcf=%b iel=%b required 1/1", a_pcf, a_iel);
      end
      tick();
      idle_inputs();
      rst = 1;
      @(negedge clk);
      vec++;
      if (a_o !== 6'b0 || a_sc !== 4'd0 || b_o !== 6'b0 || b_sc !== 16'd0) begin
         miss++; $display("FAIL reset_state: a=%b/%0d b=%b/%0d required 0", a_o, a_sc, b_o, b_sc);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         if (c == 0) load_use_inputs();
         if (c == 1) begin id_valid = 1; id_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1; end
         @(negedge clk);
         vec++;
         if ({a_o, a_sc} !== {exp_comb(0), m_to[0], 4'(m_stall[0])}) begin
            miss++; $display("FAIL load_use_fwd c%0d: got %b/%0d want %b/%0d", c, a_o, a_sc, exp_comb(0), m_stall[0]);
         end
         vec++;
         if ({b_o, b_sc} !== {exp_comb(1), m_to[1], 16'(m_stall[1])}) begin
            miss++; $display("FAIL load_use_nofwd c%0d: got %b/%0d want %b/%0d", c, b_o, b_sc, exp_comb(1), m_stall[1]);
         end
         vec++;
         if (a_o !== ((c == 0) ? 6'b110100 : 6'b000000)) begin
            miss++; $display("FAIL load_use_out c%0d: got %b", c, a_o);
         end
         if (c == 2) begin
            vec++;
            if (a_sc !== 4'd1 || b_sc !== 16'd2) begin
               miss++; $display("FAIL load_use_count: got %0d/%0d required 1/2", a_sc, b_sc);
            end
         end
         tick();
      end
   endtask

   task automatic test_non_load_raw();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         idle_inputs();
         if (c == 0) begin id_valid = 1; id_src2 = 4'd3; id_two_src = 1; exe_dest = 4'd3; exe_wb_en = 1; end
         @(negedge clk);
         vec++;
         if (a_o !== 6'b0 || b_o !== ((c == 0) ? 6'b110100 : 6'b000000)) begin
            miss++; $display("FAIL raw c%0d: fwd=%b nofwd=%b", c, a_o, b_o);
         end
         if (c == 1) begin
            vec++;
            if (a_sc !== 4'd0 || b_sc !== 16'd1) begin
               miss++; $display("FAIL raw_count: got %0d/%0d required 0/1", a_sc, b_sc);
            end
         end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         mem_req   = (c == 0);
         mem_ready = (c == 4);
         @(negedge clk);
         vec++;
         if ({a_o, a_sc} !== {exp_comb(0), m_to[0], 4'(m_stall[0])}) begin
            miss++; $display("FAIL mem_wait_model c%0d: got %b/%0d want %b/%0d", c, a_o, a_sc, exp_comb(0), m_stall[0]);
         end
         vec++;
         if (a_pf !== (c < 4) || b_pf !== (c < 4)) begin
            miss++; $display("FAIL mem_wait_freeze c%0d: got %b/%b required %b", c, a_pf, b_pf, c < 4);
         end
         if (c == 5) begin
            vec++;
            if (a_sc !== 4'd4 || b_sc !== 16'd4) begin
               miss++; $display("FAIL mem_wait_count: got %0d/%0d required 4", a_sc, b_sc);
            end
         end
         tick();
      end
   endtask

   task automatic test_deferred_branch();
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         idle_inputs();
         mem_req      = (c == 1);
         branch_taken = (c == 2);
         mem_ready    = (c == 5);
         @(negedge clk);
         vec++;
         if ({a_ifl, a_iel} !== ((c == 5) ? 2'b11 : 2'b00) || a_pcf !== (c <= 4)) begin
            miss++; $display("FAIL defer_branch c%0d: flush=%b%b pcf=%b", c, a_ifl, a_iel, a_pcf);
         end
         vec++;
         if ({b_o, b_sc} !== {exp_comb(1), m_to[1], 16'(m_stall[1])}) begin
            miss++; $display("FAIL defer_model c%0d: got %b want %b", c, b_o, exp_comb(1));
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         idle_inputs();
         mem_req = (c == 1);
         @(negedge clk);
         vec++;
         if (a_to !== (c >= 9) || b_to !== (c >= 9) || a_pf !== 1'b1) begin
            miss++; $display("FAIL timeout c%0d: to=%b/%b pf=%b required %b/1", c, a_to, b_to, a_pf, c >= 9);
         end
         tick();
      end
      rst = 0;
      @(negedge clk);
      vec++;
      if (a_pf !== 1'b0 || a_to !== 1'b1) begin
         miss++; $display("FAIL timeout_in_reset: pf=%b to=%b required 0/1", a_pf, a_to);
      end
      tick();
      rst = 1;
      @(negedge clk);
      vec++;
      if (a_to !== 1'b0 || a_sc !== 4'd0 || b_sc !== 16'd0 || a_pf !== 1'b0) begin
         miss++; $display("FAIL timeout_reset: to=%b sc=%0d/%0d pf=%b", a_to, a_sc, b_sc, a_pf);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic [5:0] want [5] = '{6'b001100, 6'b110010, 6'b110010, 6'b001100, 6'b000000};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         if (c == 0) begin load_use_inputs(); branch_taken = 1; end
         if (c == 1) begin mem_req = 1; branch_taken = 1; end
         if (c == 3) mem_ready = 1;
         @(negedge clk);
         vec++;
         if (a_o !== want[c] || b_o !== want[c]) begin
            miss++; $display("FAIL simultaneous c%0d: got %b/%b required %b", c, a_o, b_o, want[c]);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      load_use_inputs();
      repeat (20) tick();
      idle_inputs();
      @(negedge clk);
      vec++;
      if (a_sc !== 4'd15 || b_sc !== 16'd20) begin
         miss++; $display("FAIL saturation: got %0d/%0d required 15/20", a_sc, b_sc);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst          = ($urandom_range(0, 59) != 0);
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         id_two_src   = 1'($urandom);
         id_valid     = ($urandom_range(0, 3) != 0);
         exe_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = 1'($urandom);
         exe_mem_r_en = 1'($urandom);
         mem_dest     = 4'($urandom_range(0, 3));
         mem_wb_en    = 1'($urandom);
         branch_taken = ($urandom_range(0, 4) == 0);
         mem_req      = ($urandom_range(0, 3) == 0);
         mem_ready    = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         vec++;
         if ({a_o, a_sc} !== {exp_comb(0), m_to[0], 4'(m_stall[0])}) begin
            miss++; $display("FAIL random_fwd c%0d: got %b/%0d want %b%b/%0d", c, a_o, a_sc, exp_comb(0), m_to[0], m_stall[0]);
         end
         vec++;
         if ({b_o, b_sc} !== {exp_comb(1), m_to[1], 16'(m_stall[1])}) begin
            miss++; $display("FAIL random_nofwd c%0d: got %b/%0d want %b%b/%0d", c, b_o, b_sc, exp_comb(1), m_to[1], m_stall[1]);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_non_load_raw();
      test_mem_wait();
      test_deferred_branch();
      test_timeout();
      test_simultaneous();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
